// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Bundle of the decode stage's handshake, data and status
//               signals.
//               master : the environment (fetch side driver + consumer)
//               slave  : the decode stage itself
//               Signals: flush, in_valid/in_ready/in_ir/in_pc,
//               out_valid/out_ready, decoded out_* fields, ill_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 16
);
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_ir;
    logic [XLEN-1:0]      in_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [4:0]           out_opcode;
    logic [2:0]           out_funct3;
    logic [6:0]           out_funct7;
    logic [4:0]           out_rs1;
    logic [4:0]           out_rs2;
    logic [4:0]           out_rd;
    logic [2:0]           out_fmt;
    logic [XLEN-1:0]      out_imm;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output flush, in_valid, in_ir, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3,
               out_funct7, out_rs1, out_rs2, out_rd, out_fmt, out_imm,
               out_illegal, ill_cnt
    );

    modport slave (
        input  flush, in_valid, in_ir, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3,
               out_funct7, out_rs1, out_rs2, out_rd, out_fmt, out_imm,
               out_illegal, ill_cnt
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I/RV64I instruction decode stage.
//               Decodes one 32-bit instruction per cycle (combinationally on
//               the input side), stores the result in a two-entry skid
//               buffer (output register + skid register) and presents it one
//               cycle after acceptance. Includes pipeline flush and a
//               saturating count of illegal instructions handed downstream.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - decode_stage_if.slave (flush, input handshake with
//                      in_ir/in_pc, output handshake with decoded fields,
//                      ill_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);

    // ------------------------------------------------------------------------
    // Format codes and base opcodes (IR[6:2])
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_fmt_r   = 3'd0;
    localparam logic [2:0] c_fmt_i   = 3'd1;
    localparam logic [2:0] c_fmt_s   = 3'd2;
    localparam logic [2:0] c_fmt_b   = 3'd3;
    localparam logic [2:0] c_fmt_u   = 3'd4;
    localparam logic [2:0] c_fmt_j   = 3'd5;
    localparam logic [2:0] c_fmt_ill = 3'd7;

    localparam logic [4:0] c_op_load      = 5'b00000;
    localparam logic [4:0] c_op_misc_mem  = 5'b00011;
    localparam logic [4:0] c_op_op_imm    = 5'b00100;
    localparam logic [4:0] c_op_auipc     = 5'b00101;
    localparam logic [4:0] c_op_op_imm_32 = 5'b00110;
    localparam logic [4:0] c_op_store     = 5'b01000;
    localparam logic [4:0] c_op_op        = 5'b01100;
    localparam logic [4:0] c_op_lui       = 5'b01101;
    localparam logic [4:0] c_op_op_32     = 5'b01110;
    localparam logic [4:0] c_op_branch    = 5'b11000;
    localparam logic [4:0] c_op_jalr      = 5'b11001;
    localparam logic [4:0] c_op_jal       = 5'b11011;
    localparam logic [4:0] c_op_system    = 5'b11100;

    // One decoded instruction as held in either buffer entry
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } dec_t;

    // Buffer occupancy: EMPTY, ONE (out reg valid), FULL (out + skid valid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_in_ready;
    dec_t                 r_out;
    dec_t                 r_skid;
    logic [ILL_CNT_W-1:0] r_ill_cnt;

    dec_t                 w_dec;
    logic [31:0]          w_ir;
    logic [2:0]           w_fmt;
    logic                 w_rv64_ops;
    logic                 w_out_valid;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_load_out_in;
    logic                 w_load_out_skid;
    logic                 w_load_skid;

    // ------------------------------------------------------------------------
    // The *-32 word opcodes only exist on a 64-bit datapath
    // ------------------------------------------------------------------------
    generate
        if (XLEN == 64) begin : g_rv64
            assign w_rv64_ops = 1'b1;
        end else begin : g_rv32
            assign w_rv64_ops = 1'b0;
        end
    endgenerate

    assign w_ir = bus.in_ir;

    // ------------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------------
    always_comb begin
        w_fmt = c_fmt_ill;
        // Compressed / non-32-bit encodings are never a base opcode
        if (w_ir[1:0] == 2'b11) begin
            case (w_ir[6:2])
                c_op_lui,
                c_op_auipc:     w_fmt = c_fmt_u;
                c_op_jal:       w_fmt = c_fmt_j;
                c_op_jalr,
                c_op_load,
                c_op_op_imm,
                c_op_misc_mem,
                c_op_system:    w_fmt = c_fmt_i;
                c_op_store:     w_fmt = c_fmt_s;
                c_op_branch:    w_fmt = c_fmt_b;
                c_op_op:        w_fmt = c_fmt_r;
                c_op_op_imm_32: w_fmt = w_rv64_ops ? c_fmt_i : c_fmt_ill;
                c_op_op_32:     w_fmt = w_rv64_ops ? c_fmt_r : c_fmt_ill;
                default:        w_fmt = c_fmt_ill;
            endcase
        end
    end

    always_comb begin
        w_dec         = '0;
        // Raw fields pass through regardless of legality
        w_dec.pc      = bus.in_pc;
        w_dec.opcode  = w_ir[6:2];
        w_dec.funct3  = w_ir[14:12];
        w_dec.funct7  = w_ir[31:25];
        w_dec.rs1     = w_ir[19:15];
        w_dec.rs2     = w_ir[24:20];
        w_dec.rd      = w_ir[11:7];
        w_dec.fmt     = w_fmt;
        w_dec.illegal = (w_fmt == c_fmt_ill);
        // Every immediate takes its sign from IR[31]; the replicated sign
        // covers IR[31]'s own position so the explicit slices start at 30.
        case (w_fmt)
            c_fmt_i: w_dec.imm = {{(XLEN-11){w_ir[31]}}, w_ir[30:20]};
            c_fmt_s: w_dec.imm = {{(XLEN-11){w_ir[31]}}, w_ir[30:25],
                                  w_ir[11:7]};
            c_fmt_b: w_dec.imm = {{(XLEN-12){w_ir[31]}}, w_ir[7],
                                  w_ir[30:25], w_ir[11:8], 1'b0};
            c_fmt_u: w_dec.imm = {{(XLEN-31){w_ir[31]}}, w_ir[30:12],
                                  12'b0};
            c_fmt_j: w_dec.imm = {{(XLEN-20){w_ir[31]}}, w_ir[19:12],
                                  w_ir[20], w_ir[30:21], 1'b0};
            default: w_dec.imm = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Handshake qualifiers. in_ready comes from a register so that it never
    // depends combinationally on out_ready.
    // ------------------------------------------------------------------------
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

    // ------------------------------------------------------------------------
    // Buffer FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Buffer FSM: next state and entry load controls
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && !w_drain) begin
                    // Output register is stalled; new word parks in skid
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_accept && w_drain) begin
                    w_load_out_in = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a drain can happen
                if (w_drain) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush discards everything buffered plus any same-cycle accept
        if (bus.flush) begin
            w_state_nxt     = ST_EMPTY;
            w_load_out_in   = 1'b0;
            w_load_out_skid = 1'b0;
            w_load_skid     = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers and illegal-instruction counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
            r_ill_cnt  <= '0;
        end else begin
            r_in_ready <= (w_state_nxt != ST_FULL);
            if (w_load_out_in) begin
                r_out <= w_dec;
            end else if (w_load_out_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_dec;
            end
            // Counts illegal words actually handed downstream, including a
            // drain in a flush cycle; flush never clears it.
            if (w_drain && r_out.illegal && !(&r_ill_cnt)) begin
                r_ill_cnt <= r_ill_cnt + ILL_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_pc      = r_out.pc;
    assign bus.out_opcode  = r_out.opcode;
    assign bus.out_funct3  = r_out.funct3;
    assign bus.out_funct7  = r_out.funct7;
    assign bus.out_rs1     = r_out.rs1;
    assign bus.out_rs2     = r_out.rs2;
    assign bus.out_rd      = r_out.rd;
    assign bus.out_fmt     = r_out.fmt;
    assign bus.out_imm     = r_out.imm;
    assign bus.out_illegal = r_out.illegal;
    assign bus.ill_cnt     = r_ill_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. Two instances run in
//               lockstep on identical stimulus: A (XLEN=32, ILL_CNT_W=2) and
//               B (XLEN=64, ILL_CNT_W=16). A queue-based reference model
//               predicts occupancy, output contents and illegal counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [63:0] pc = '0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .ILL_CNT_W(2))  bus_a ();
    decode_stage_if #(.XLEN(64), .ILL_CNT_W(16)) bus_b ();

    assign bus_a.flush     = flush;
    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_ir     = ir;
    assign bus_a.in_pc     = pc[31:0];
    assign bus_a.out_ready = out_ready;
    assign bus_b.flush     = flush;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_ir     = ir;
    assign bus_b.in_pc     = pc;
    assign bus_b.out_ready = out_ready;

    decode_stage #(.XLEN(32), .ILL_CNT_W(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    decode_stage #(.XLEN(64), .ILL_CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // ------------------------------------------------------------------------
    // Reference model state: FIFO of accepted (ir, pc) pairs, capacity 2
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] ir;
        logic [63:0] pc;
    } item_t;

    item_t q[$];
    int    ill_a = 0;
    int    ill_b = 0;
    int    tests = 0;
    int    fails = 0;

    // Expected decode, computed with signed arithmetic from the ISA rules.
    // Layout: {pc, opcode, funct3, funct7, rs1, rs2, rd, fmt, imm, illegal}
    function automatic logic [161:0] model(input logic [31:0] mir,
                                           input logic [63:0] mpc,
                                           input bit rv64);
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic [63:0] p;
        longint      s;
        longint      sg;
        fmt = 3'd7;
        if (mir[1:0] == 2'b11) begin
            case (mir[6:2])
                5'b01101, 5'b00101: fmt = 3'd4;
                5'b11011:           fmt = 3'd5;
                5'b11001, 5'b00000, 5'b00100,
                5'b00011, 5'b11100: fmt = 3'd1;
                5'b01000:           fmt = 3'd2;
                5'b11000:           fmt = 3'd3;
                5'b01100:           fmt = 3'd0;
                5'b00110:           if (rv64) fmt = 3'd1;
                5'b01110:           if (rv64) fmt = 3'd0;
                default:            fmt = 3'd7;
            endcase
        end
        s  = longint'($signed(mir));
        sg = s >>> 63;
        case (fmt)
            3'd1: imm = s >>> 20;
            3'd2: imm = (s >>> 25) * 32 + longint'(mir[11:7]);
            3'd3: imm = sg * 4096 + longint'(mir[7]) * 2048
                        + longint'(mir[30:25]) * 32 + longint'(mir[11:8]) * 2;
            3'd4: imm = s - longint'(mir[11:0]);
            3'd5: imm = sg * 1048576 + longint'(mir[19:12]) * 4096
                        + longint'(mir[20]) * 2048 + longint'(mir[30:21]) * 2;
            default: imm = 64'd0;
        endcase
        p = mpc;
        if (!rv64) begin
            imm = {32'b0, imm[31:0]};
            p   = {32'b0, mpc[31:0]};
        end
        return {p, mir[6:2], mir[14:12], mir[31:25], mir[19:15], mir[24:20],
                mir[11:7], fmt, imm, (fmt == 3'd7)};
    endfunction

    function automatic logic [161:0] obs_a();
        return {32'b0, bus_a.out_pc, bus_a.out_opcode, bus_a.out_funct3,
                bus_a.out_funct7, bus_a.out_rs1, bus_a.out_rs2, bus_a.out_rd,
                bus_a.out_fmt, 32'b0, bus_a.out_imm, bus_a.out_illegal};
    endfunction

    function automatic logic [161:0] obs_b();
        return {bus_b.out_pc, bus_b.out_opcode, bus_b.out_funct3,
                bus_b.out_funct7, bus_b.out_rs1, bus_b.out_rs2, bus_b.out_rd,
                bus_b.out_fmt, bus_b.out_imm, bus_b.out_illegal};
    endfunction

    task automatic chk(input string tag, input logic [161:0] obs,
                       input logic [161:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the model's view of the current cycle
    task automatic check_outputs();
        chk("ctl_a", {bus_a.in_ready, bus_a.out_valid, 16'(bus_a.ill_cnt)},
            {q.size() < 2, q.size() > 0, 16'(ill_a)});
        chk("ctl_b", {bus_b.in_ready, bus_b.out_valid, bus_b.ill_cnt},
            {q.size() < 2, q.size() > 0, 16'(ill_b)});
        if (q.size() > 0) begin
            chk("data_a", obs_a(), model(q[0].ir, q[0].pc, 1'b0));
            chk("data_b", obs_b(), model(q[0].ir, q[0].pc, 1'b1));
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model
    task automatic step(input bit v, input logic [31:0] sir,
                        input logic [63:0] spc, input bit ordy,
                        input bit fl, output bit acc);
        bit          drn;
        logic [161:0] e;
        in_valid  = v;
        ir        = sir;
        pc        = spc;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        acc = v && (q.size() < 2);
        drn = (q.size() > 0) && ordy;
        @(posedge clk);
        if (drn) begin
            e = model(q[0].ir, q[0].pc, 1'b0);
            if (e[0] && ill_a < 3) ill_a++;
            e = model(q[0].ir, q[0].pc, 1'b1);
            if (e[0] && ill_b < 65535) ill_b++;
            void'(q.pop_front());
        end
        if (fl) q.delete();
        else if (acc) q.push_back('{ir: sir, pc: spc});
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        ill_a = 0;
        ill_b = 0;
        chk("rst_data_a", obs_a(), '0);
        chk("rst_data_b", obs_b(), '0);
        chk("rst_ctl_a", {bus_a.in_ready, bus_a.out_valid, 16'(bus_a.ill_cnt)},
            {1'b1, 1'b0, 16'd0});
        chk("rst_ctl_b", {bus_b.in_ready, bus_b.out_valid, bus_b.ill_cnt},
            {1'b1, 1'b0, 16'd0});
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 4) != 0) r[1:0] = 2'b11;
        return r;
    endfunction

    logic [31:0] bp [4] = '{32'h00500113, 32'h00A12023, 32'h00C0006F,
                            32'h40208033};
    logic [31:0] illv [5] = '{32'h00000000, 32'h0000001B, 32'h00000002,
                              32'h0000007F, 32'h00000000};

    initial begin
        bit          acc;
        int          k;
        logic [31:0] cur_ir;
        logic [63:0] cur_pc;

        // ---------------- reset state ----------------
        do_reset();

        // ---------------- basic immediates ----------------
        step(1, 32'hFFF00093, 64'h100, 1, 0, acc);
        chk("kat_addi", {bus_a.out_valid, bus_a.out_fmt, bus_a.out_rd,
                         bus_a.out_rs1, bus_a.out_imm},
            {1'b1, 3'd1, 5'd1, 5'd0, 32'hFFFFFFFF});
        step(1, 32'h123452B7, 64'h104, 1, 0, acc);
        chk("kat_lui", {bus_a.out_fmt, bus_a.out_rd, bus_a.out_imm},
            {3'd4, 5'd5, 32'h12345000});
        step(1, 32'hFE000EE3, 64'h108, 1, 0, acc);
        chk("kat_beq", {bus_a.out_fmt, bus_a.out_imm}, {3'd3, 32'hFFFFFFFC});

        // ---------------- XLEN=64 specifics ----------------
        step(1, 32'hFFF0009B, 64'hFFFF_0000_0000_010C, 1, 0, acc);
        chk("kat_addiw_b", {bus_b.out_illegal, bus_b.out_fmt, bus_b.out_imm},
            {1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF});
        chk("kat_addiw_a", {bus_a.out_illegal, bus_a.out_fmt, bus_a.out_imm},
            {1'b1, 3'd7, 32'h0});
        step(1, 32'h800000B7, 64'h110, 1, 0, acc);
        chk("kat_lui64", {bus_b.out_imm, bus_a.out_imm},
            {64'hFFFFFFFF80000000, 32'h80000000});
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // ---------------- backpressure ----------------
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step(k < 4, (k < 4) ? bp[k] : 32'h0, 64'h2000 + 64'(k * 4),
                 c >= 6, 1'b0, acc);
            if (acc) k++;
            if (c == 1) chk("bp_ready_low", bus_a.in_ready, 1'b0);
        end
        chk("bp_all_accepted", k, 4);

        // ---------------- illegal + saturating counter ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, illv[i], 64'h3000 + 64'(i * 4), 1, 0, acc);
            if (i == 0) chk("kat_zero", {bus_a.out_fmt, bus_a.out_illegal,
                                         bus_a.out_imm}, {3'd7, 1'b1, 32'h0});
        end
        step(0, 32'h0, 64'h0, 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);
        chk("cnt_sat_a", bus_a.ill_cnt, 2'd3);
        chk("cnt_b", bus_b.ill_cnt, 16'd4);

        // ---------------- flush from FULL ----------------
        step(1, 32'h00100093, 64'h4000, 0, 0, acc);
        step(1, 32'h00200113, 64'h4004, 0, 0, acc);
        step(1, 32'h00300193, 64'h4008, 0, 1, acc);
        chk("flush_state", {bus_a.out_valid, bus_a.in_ready,
                            bus_b.out_valid, bus_b.in_ready}, 4'b0101);
        step(0, 32'h0, 64'h0, 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // ---------------- reset mid-stream ----------------
        step(1, 32'h00000000, 64'h5000, 1, 0, acc);
        step(1, 32'h00400213, 64'h5004, 1, 0, acc);
        step(1, 32'h00500293, 64'h5008, 0, 0, acc);
        step(0, 32'h0, 64'h0, 0, 0, acc);
        do_reset();

        // ---------------- randomized traffic ----------------
        cur_ir = rand_ir();
        cur_pc = {$urandom, $urandom};
        for (int c = 0; c < 800; c++) begin
            bit v, ordy, fl;
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 29) == 0);
            step(v, cur_ir, cur_pc, ordy, fl, acc);
            if (acc || fl) begin
                cur_ir = rand_ir();
                cur_pc = {$urandom, $urandom};
            end
        end
        for (int c = 0; c < 3; c++) step(0, 32'h0, 64'h0, 1, 0, acc);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Registered RV32I/RV64I instruction decode stage that sits between the fetch buffer and the register-read/execute stage. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake, and emits fields, format, a single sign-extended immediate and an illegal flag one cycle later. A two-entry skid buffer gives full throughput under backpressure. A pipeline flush and a saturating illegal-instruction counter are included.

## Interface
- XLEN, 32, datapath width for PC and immediate; legal values 32 and 64.
- ILL_CNT_W, 16, width of the saturating illegal-instruction counter.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  drop all buffered instructions this cycle.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept an instruction.
- in_ir  input  32  instruction word.
- in_pc  input  XLEN  instruction PC.
- out_valid  output  1  decoded instruction valid.
- out_ready  input  1  downstream accepts the decoded instruction.
- out_pc  output  XLEN  PC of the decoded instruction.
- out_opcode  output  5  IR[6:2].
- out_funct3  output  3  IR[14:12].
- out_funct7  output  7  IR[31:25].
- out_rs1, out_rs2, out_rd  output  5 each  IR[19:15], IR[24:20], IR[11:7].
- out_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_imm  output  XLEN  immediate for out_fmt, sign-extended to XLEN; 0 for R and illegal.
- out_illegal  output  1  instruction is not a recognised base opcode.
- ill_cnt  output  ILL_CNT_W  count of illegal instructions handed downstream; saturates at all-ones.

## Operation
- Format by opcode (IR[6:2]):
  - 01101 LUI and 00101 AUIPC -> U.
  - 11011 JAL -> J.
  - 11001 JALR, 00000 LOAD, 00100 OP-IMM, 00011 MISC-MEM, 11100 SYSTEM -> I.
  - 01000 STORE -> S.
  - 11000 BRANCH -> B.
  - 01100 OP -> R.
  - When XLEN=64 only: 00110 OP-IMM-32 -> I, 01110 OP-32 -> R.
- Illegal: IR[1:0] != 2'b11, or any opcode not listed above. An illegal instruction gets fmt=7, imm=0 and out_illegal=1. Its other fields pass through raw.
- Immediates, each sign-extended from IR[31] to XLEN:
  - I = IR[31:20].
  - S = {IR[31:25], IR[11:7]}.
  - B = {IR[31], IR[7], IR[30:25], IR[11:8], 0}.
  - U = {IR[31:12], 12'b0}; for XLEN=64 bits 63:32 copy bit 31.
  - J = {IR[31], IR[19:12], IR[20], IR[30:21], 0}.
- Decode is combinational on the input side. The results are stored in the output register (entry 0) or the skid register (entry 1).
- Buffer state: EMPTY (no entry), ONE (out reg valid), FULL (out and skid valid).
  - EMPTY: an accepted input goes to ONE.
  - ONE:
    - accept and no drain: go to FULL, input lands in skid.
    - accept and drain: stay ONE, out reg reloads.
    - drain only: go to EMPTY.
  - FULL:
    - drain: go to ONE, skid moves to out reg.
    - no drain: hold. Input is never accepted in FULL.
- in_ready = not FULL. It is driven from a register, not from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- out_valid = state != EMPTY. While out_valid=1 and out_ready=0, all out_* stay stable.
- ill_cnt increments by 1 on each drain with out_illegal=1, unless already all-ones.
- flush:
  - Next state is EMPTY. Any accept in the same cycle is discarded.
  - A drain in the flush cycle still counts for ill_cnt.
  - ill_cnt is not cleared by flush.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N.
- Throughput is 1 instruction per cycle with out_ready held high.
- Reset values:
  - state=EMPTY, out_valid=0, in_ready=1.
  - All out_* data = 0 and out_fmt=0.
  - ill_cnt=0.
- rst overrides flush and all handshakes. rst asserted mid-stream loses all buffered instructions.
- Simultaneous accept and drain in FULL cannot occur, because in_ready=0.
- Order is strictly FIFO.

## Test plan
- Basic immediates, XLEN=32:
  - 0xFFF00093 (addi x1,x0,-1) -> fmt=1, rd=1, rs1=0, imm=0xFFFFFFFF, one cycle after accept.
  - 0x123452B7 (lui x5) -> fmt=4, rd=5, imm=0x12345000.
  - 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC.
- Backpressure: stream 4 back-to-back instructions with out_ready=0 for 3 cycles.
  - in_ready falls after the 2nd accept.
  - Holding out_ready low longer keeps all outputs stable.
  - On release, all 4 emerge in order with no loss or duplication.
- Illegal and counter:
  - 0x00000000 -> fmt=7, out_illegal=1, imm=0, ill_cnt becomes 1.
  - 0x0000001B (OP-IMM-32) at XLEN=32 is illegal.
  - With ILL_CNT_W=2, five illegal drains leave ill_cnt=3.
- Flush: reach FULL, then assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, and nothing from before the flush appears.
- XLEN=64:
  - 0xFFF0009B (addiw) -> legal, fmt=1, imm=0xFFFFFFFFFFFFFFFF.
  - 0x800000B7 (lui) -> imm=0xFFFFFFFF80000000.
- Reset mid-stream: assert rst while FULL -> next cycle all outputs at reset values, ill_cnt=0.
